inst_axi_bridge: RTL and testbench

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge_if.sv | 51 +++++
 rtl/inst_axi_bridge.sv | 75 +++++++
 tb/tb_inst_axi_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_bridge_if.sv
// Bundle of the instruction SRAM-like request port and the AXI AR/R channels.
// master: the bridge side. slave: the IF stage plus the AXI slave, both driven by the environment.
interface inst_axi_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction-fetch to AXI read bridge: one AR in flight, up to MAX_OUTSTANDING reads, in-order single-ID returns.
// addr_ok is same-cycle in AR_IDLE; R passes through with zero latency; arready low stalls new requests.
module inst_axi_bridge #(
  parameter logic [3:0] ARID_VAL        = 4'h0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               reset,
  inst_axi_bridge_if.master bus
);
  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;
  localparam logic [1:0] CNT_MAX = 2'(MAX_OUTSTANDING);

  logic [0:0]  ar_state;
  logic [1:0]  cnt;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        rst_q;
  logic        addr_ok;
  logic        data_ok;
  logic        unused_ok;

  // rst_q holds off new requests for the first cycle after reset drops
  always_ff @(posedge clk) begin
    rst_q <= reset;
  end

  assign addr_ok = !reset && !rst_q && (ar_state == AR_IDLE) &&
                   bus.inst_sram_req && !bus.inst_sram_wr && (cnt < CNT_MAX);
  assign data_ok = bus.rvalid && bus.rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      cnt      <= 2'd0;
      ar_addr  <= 32'd0;
      ar_size  <= 3'd0;
    end else begin
      if (ar_state == AR_IDLE) begin
        if (addr_ok) begin
          ar_addr  <= bus.inst_sram_addr;
          ar_size  <= {1'b0, bus.inst_sram_size};
          ar_state <= AR_BUSY;
        end
      end else if (bus.arready) begin
        ar_state <= AR_IDLE;
      end

      if (addr_ok && !data_ok) begin
        cnt <= cnt + 2'd1;
      end else if (data_ok && !addr_ok) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = data_ok;
  assign bus.inst_sram_rdata   = bus.rdata;

  assign bus.arid    = ARID_VAL;
  assign bus.araddr  = ar_addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = ar_size;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = !reset && (ar_state == AR_BUSY);
  assign bus.rready  = !reset && (cnt != 2'd0);

  // write path, strobes, and R sideband are intentionally not consumed
  assign unused_ok = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rresp, bus.rlast};
endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: reset/idle vector table, directed multi-cycle corners, random run against a queue model.
module tb_inst_axi_bridge;
  localparam logic [3:0]  ARID = 4'h9;
  localparam int          MAX  = 2;
  localparam logic [31:0] KEY  = 32'ha5a5_5a5a;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_axi_bridge_if bus ();

  inst_axi_bridge #(.ARID_VAL(ARID), .MAX_OUTSTANDING(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ok;
    logic [31:0] araddr;
    logic [2:0]  arsize;
  } vec_t;

  vec_t vecs[7];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_wr    = 1'b0;
    bus.inst_sram_size  = 2'd0;
    bus.inst_sram_wstrb = 4'd0;
    bus.inst_sram_addr  = 32'd0;
    bus.inst_sram_wdata = 32'd0;
    bus.arready         = 1'b0;
    bus.rid             = 4'd0;
    bus.rdata           = 32'd0;
    bus.rresp           = 2'd0;
    bus.rlast           = 1'b1;
    bus.rvalid          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc_q[$];
    logic [31:0] arq[$];
    logic [31:0] slv_q[$];
    logic        e_arvalid, e_addr_ok, e_data_ok;

    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h1c00_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h1c00_0000, 3'd2};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 32'h1c00_0004, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 32'h1c00_0008, 1'b1, 32'hcafe_f00d, 1'b0, 32'h0000_0000, 3'd0};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 32'hdead_beef, 1'b0, 32'h0000_0000, 1'b1, 32'hdead_beef, 3'd0};
    vecs[4] = '{1'b1, 1'b0, 2'd3, 32'hffff_fffc, 1'b0, 32'h0000_0000, 1'b1, 32'hffff_fffc, 3'd3};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 32'h0000_0002, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0002, 3'd1};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 32'h0000_0055, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};

    // reset behaviour with a request already pending
    idle_inputs();
    reset = 1'b1;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0000;
    cyc();
    mid();
    chk1("rst_addr_ok", bus.inst_sram_addr_ok, 1'b0);
    chk1("rst_arvalid", bus.arvalid, 1'b0);
    chk1("rst_rready", bus.rready, 1'b0);
    chk1("rst_data_ok", bus.inst_sram_data_ok, 1'b0);
    chk32("rst_araddr", bus.araddr, 32'd0);
    cyc();
    reset = 1'b0;
    mid();
    chk1("post_rst_addr_ok", bus.inst_sram_addr_ok, 1'b0);
    chk32("post_rst_cnt", 32'(dut.cnt), 32'd0);

    // idle-state vector table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.inst_sram_req  = vecs[i].req;
      bus.inst_sram_wr   = vecs[i].wr;
      bus.inst_sram_size = vecs[i].size;
      bus.inst_sram_addr = vecs[i].addr;
      bus.rvalid         = vecs[i].rvalid;
      bus.rdata          = vecs[i].rdata;
      mid();
      chk1($sformatf("vec%0d_addr_ok", i), bus.inst_sram_addr_ok, vecs[i].ok);
      chk1($sformatf("vec%0d_data_ok", i), bus.inst_sram_data_ok, 1'b0);
      chk32($sformatf("vec%0d_rdata", i), bus.inst_sram_rdata, vecs[i].rdata);
      cyc();
      idle_inputs();
      mid();
      chk1($sformatf("vec%0d_arvalid", i), bus.arvalid, vecs[i].ok);
      chk32($sformatf("vec%0d_araddr", i), bus.araddr, vecs[i].araddr);
      chk32($sformatf("vec%0d_arsize", i), 32'(bus.arsize), 32'(vecs[i].arsize));
    end

    // single fetch end to end
    do_reset();
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0000;
    bus.inst_sram_size = 2'd2;
    mid();
    chk1("sf_addr_ok", bus.inst_sram_addr_ok, 1'b1);
    chk1("sf_arvalid0", bus.arvalid, 1'b0);
    cyc();
    bus.inst_sram_req = 1'b0;
    bus.arready       = 1'b1;
    mid();
    chk1("sf_arvalid1", bus.arvalid, 1'b1);
    chk32("sf_araddr", bus.araddr, 32'h1c00_0000);
    chk32("sf_arsize", 32'(bus.arsize), 32'd2);
    chk32("sf_arid", 32'(bus.arid), 32'(ARID));
    chk32("sf_arlen", 32'(bus.arlen), 32'd0);
    chk32("sf_arburst", 32'(bus.arburst), 32'd1);
    chk32("sf_lock_cache_prot", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
    cyc();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h02c0_0000;
    mid();
    chk1("sf_arvalid2", bus.arvalid, 1'b0);
    chk1("sf_rready", bus.rready, 1'b1);
    chk1("sf_data_ok", bus.inst_sram_data_ok, 1'b1);
    chk32("sf_rdata", bus.inst_sram_rdata, 32'h02c0_0000);
    cyc();
    bus.rvalid = 1'b0;
    mid();
    chk32("sf_cnt_end", 32'(dut.cnt), 32'd0);
    chk1("sf_rready_end", bus.rready, 1'b0);

    // AR backpressure for five cycles with a request held
    do_reset();
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h0000_1000;
    bus.inst_sram_size = 2'd2;
    mid();
    chk1("bp_addr_ok0", bus.inst_sram_addr_ok, 1'b1);
    cyc();
    bus.inst_sram_addr = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk1($sformatf("bp_arvalid_%0d", i), bus.arvalid, 1'b1);
      chk32($sformatf("bp_araddr_%0d", i), bus.araddr, 32'h0000_1000);
      chk1($sformatf("bp_addr_ok_%0d", i), bus.inst_sram_addr_ok, 1'b0);
      cyc();
    end
    bus.arready = 1'b1;
    mid();
    chk1("bp_hs_addr_ok", bus.inst_sram_addr_ok, 1'b0);
    cyc();
    bus.arready = 1'b0;
    mid();
    chk1("bp_next_addr_ok", bus.inst_sram_addr_ok, 1'b1);
    cyc();
    bus.inst_sram_req = 1'b0;
    mid();
    chk32("bp_araddr_next", bus.araddr, 32'h0000_2000);

    // outstanding limit, and a return while full
    do_reset();
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h0000_3000;
    bus.arready        = 1'b1;
    mid();
    chk1("ol_ok0", bus.inst_sram_addr_ok, 1'b1);
    cyc();
    mid();
    cyc();
    bus.inst_sram_addr = 32'h0000_3004;
    mid();
    chk1("ol_ok1", bus.inst_sram_addr_ok, 1'b1);
    cyc();
    mid();
    cyc();
    mid();
    chk32("ol_cnt_full", 32'(dut.cnt), 32'd2);
    chk1("ol_blocked", bus.inst_sram_addr_ok, 1'b0);
    chk1("ol_rready", bus.rready, 1'b1);
    cyc();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0000_0bad;
    mid();
    chk1("ol_full_ret_data_ok", bus.inst_sram_data_ok, 1'b1);
    chk1("ol_full_ret_addr_ok", bus.inst_sram_addr_ok, 1'b0);
    cyc();
    bus.rvalid = 1'b0;
    mid();
    chk1("ol_reopen", bus.inst_sram_addr_ok, 1'b1);
    cyc();
    bus.inst_sram_req = 1'b0;
    mid();
    chk32("ol_cnt_refill", 32'(dut.cnt), 32'd2);

    // simultaneous accept and return at cnt = 1
    do_reset();
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h0000_4000;
    bus.arready        = 1'b1;
    mid();
    cyc();
    mid();
    cyc();
    bus.inst_sram_addr = 32'h0000_4004;
    bus.rvalid         = 1'b1;
    bus.rdata          = 32'h0000_4444;
    mid();
    chk1("sim_addr_ok", bus.inst_sram_addr_ok, 1'b1);
    chk1("sim_data_ok", bus.inst_sram_data_ok, 1'b1);
    cyc();
    bus.inst_sram_req = 1'b0;
    bus.rvalid        = 1'b0;
    mid();
    chk32("sim_cnt", 32'(dut.cnt), 32'd1);

    // write requests are never accepted
    do_reset();
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_wr   = 1'b1;
    bus.inst_sram_addr = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk1($sformatf("wr_addr_ok_%0d", i), bus.inst_sram_addr_ok, 1'b0);
      chk1($sformatf("wr_arvalid_%0d", i), bus.arvalid, 1'b0);
      cyc();
    end

    // reset mid-transaction
    do_reset();
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h0000_6000;
    mid();
    cyc();
    bus.inst_sram_req = 1'b0;
    mid();
    chk1("mr_arvalid_before", bus.arvalid, 1'b1);
    chk32("mr_cnt_before", 32'(dut.cnt), 32'd1);
    #1;
    reset = 1'b1;
    cyc();
    mid();
    chk1("mr_arvalid_after", bus.arvalid, 1'b0);
    chk32("mr_cnt_after", 32'(dut.cnt), 32'd0);
    chk1("mr_rready_after", bus.rready, 1'b0);
    reset = 1'b0;

    // random traffic against an in-order queue model of the bridge and an AXI slave
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.inst_sram_req  = ($urandom_range(3) != 0);
      bus.inst_sram_wr   = ($urandom_range(7) == 0);
      bus.inst_sram_size = 2'($urandom_range(3));
      bus.inst_sram_addr = $urandom & 32'hffff_fffc;
      bus.arready        = 1'($urandom_range(1));
      bus.rvalid         = (slv_q.size() != 0) && ($urandom_range(2) != 0);
      bus.rdata          = bus.rvalid ? (slv_q[0] ^ KEY) : $urandom;
      mid();
      e_arvalid = (arq.size() != 0);
      e_addr_ok = bus.inst_sram_req && !bus.inst_sram_wr && !e_arvalid && (acc_q.size() < MAX);
      e_data_ok = bus.rvalid && (acc_q.size() != 0);
      chk1("rnd_addr_ok", bus.inst_sram_addr_ok, e_addr_ok);
      chk1("rnd_arvalid", bus.arvalid, e_arvalid);
      chk1("rnd_rready", bus.rready, acc_q.size() != 0);
      chk1("rnd_data_ok", bus.inst_sram_data_ok, e_data_ok);
      if (e_arvalid) chk32("rnd_araddr", bus.araddr, arq[0]);
      if (e_data_ok) chk32("rnd_rdata", bus.inst_sram_rdata, acc_q[0] ^ KEY);
      if (e_arvalid && bus.arready) slv_q.push_back(arq.pop_front());
      if (e_data_ok) begin
        void'(acc_q.pop_front());
        void'(slv_q.pop_front());
      end
      if (e_addr_ok) begin
        acc_q.push_back(bus.inst_sram_addr);
        arq.push_back(bus.inst_sram_addr);
      end
      cyc();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
